// File: rtl/pcs_pkg.sv
// Shared constants and types for the PCS transmit path.
package pcs_pkg;

  typedef logic [5:0] seq_t;

  localparam int   DATA_WIDTH = 64;
  localparam int   HDR_WIDTH  = 2;
  localparam int   BLK_WIDTH  = DATA_WIDTH + HDR_WIDTH;
  localparam seq_t SEQ_MAX    = 6'd32;

  localparam logic [HDR_WIDTH-1:0] SYNC_DATA = 2'b01;
  localparam logic [HDR_WIDTH-1:0] SYNC_CTRL = 2'b10;

endpackage

// File: rtl/pcs_tx_gearbox.sv
// 66-to-64 transmit gearbox: packs one 66-bit block per cycle into 64-bit GTY words,
// pausing the encoder once every 33 cycles to flush the accumulated residual.
module pcs_tx_gearbox
  import pcs_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [HDR_WIDTH-1:0]  i_hdr,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_gty_data,
  output logic                  o_gty_valid,
  output logic [5:0]            o_gty_seq
);

  seq_t                  seq_q, seq_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [DATA_WIDTH-1:0] gty_data_q, gty_data_d;
  logic                  gty_valid_q, gty_valid_d;
  seq_t                  gty_seq_q, gty_seq_d;
  logic [127:0]          packed_w;

  // Returns {word, new_res}; the 128-bit intermediate keeps the bits shifted past 64.
  function automatic logic [127:0] pack(input logic [BLK_WIDTH-1:0]  blk,
                                        input logic [DATA_WIDTH-1:0] res,
                                        input seq_t                  seq);
    logic [6:0]   sh;
    logic [127:0] wide;
    sh   = {seq, 1'b0};
    wide = {62'b0, blk} << sh;
    return {wide[63:0] | res, wide[127:64]};
  endfunction

  assign o_ready = (seq_q != SEQ_MAX);

  always_comb begin
    seq_d       = seq_q;
    res_d       = res_q;
    gty_data_d  = gty_data_q;
    gty_valid_d = 1'b0;
    gty_seq_d   = gty_seq_q;
    packed_w    = '0;
    if (seq_q == SEQ_MAX) begin
      gty_data_d  = res_q;
      gty_valid_d = 1'b1;
      gty_seq_d   = seq_q;
      res_d       = '0;
      seq_d       = '0;
    end else if (i_valid) begin
      packed_w    = pack({i_data, i_hdr}, res_q, seq_q);
      gty_data_d  = packed_w[127:64];
      res_d       = packed_w[63:0];
      gty_valid_d = 1'b1;
      gty_seq_d   = seq_q;
      seq_d       = seq_q + 6'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      seq_q       <= '0;
      res_q       <= '0;
      gty_data_q  <= '0;
      gty_valid_q <= 1'b0;
      gty_seq_q   <= '0;
    end else begin
      seq_q       <= seq_d;
      res_q       <= res_d;
      gty_data_q  <= gty_data_d;
      gty_valid_q <= gty_valid_d;
      gty_seq_q   <= gty_seq_d;
    end
  end

  assign o_gty_data  = gty_data_q;
  assign o_gty_valid = gty_valid_q;
  assign o_gty_seq   = gty_seq_q;

endmodule
